// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller.
//   - stall vector encodings (bit 0 = PC ... bit 5 = WB, 1 = hold)
//   - controller FSM state codes
//   - redirect event kinds, numerically ordered by priority
//   - reset PC
//   - run_stall(): RUN-state stall vector from the per-stage requests
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PEND  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Ordered so that a larger code always means a higher-priority event;
  // the controller relies on this for its "higher priority wins" compare.
  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_MISP = 2'd1,
    EV_MRET = 2'd2,
    EV_EXCP = 2'd3
  } ev_kind_t;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_ALL  = 6'b111111;

  localparam logic [31:0] RESET_PC = 32'h3000_0000;

  // The deepest stalling stage wins: it must also hold everything upstream.
  function automatic logic [5:0] run_stall(input logic req_if, input logic req_id,
                                           input logic req_ex, input logic req_mem);
    logic [5:0] s;
    if (req_mem)     s = STALL_MEM;
    else if (req_ex) s = STALL_EX;
    else if (req_id) s = STALL_ID;
    else if (req_if) s = STALL_IF;
    else             s = STALL_NONE;
    return s;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Signal bundle between the pipeline and its controller.
//   master: the pipeline side (drives requests/events, receives stall/flush)
//   slave : pipe_ctrl (receives requests/events, drives stall/flush/CSR port)
// dbg_state exposes the controller FSM state for observation.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic        mispredict_i;
  logic [31:0] real_tar_addr_i;
  logic        excp_valid_i;
  logic [4:0]  excp_code_i;
  logic [31:0] excp_pc_i;
  logic [31:0] mtvec_i;
  logic        mret_i;
  logic [31:0] mepc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        mepc_we_o;
  logic [31:0] mepc_o;
  logic [4:0]  mcause_o;
  state_t      dbg_state;

  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    output mispredict_i, real_tar_addr_i,
    output excp_valid_i, excp_code_i, excp_pc_i, mtvec_i,
    output mret_i, mepc_i,
    input  stall, flush, new_pc, mepc_we_o, mepc_o, mcause_o, dbg_state
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    input  mispredict_i, real_tar_addr_i,
    input  excp_valid_i, excp_code_i, excp_pc_i, mtvec_i,
    input  mret_i, mepc_i,
    output stall, flush, new_pc, mepc_we_o, mepc_o, mcause_o, dbg_state
  );
endinterface

// File: rtl/pipe_ctrl_redirect_sel.sv
// redirect_sel: combinational priority selector for redirect events.
//   Inputs : excp_valid, mret, mispredict strobes and their targets.
//   Outputs: kind   - winning event (EV_NONE when nothing is requested)
//            target - redirect PC for the winning event
// Priority: exception > mret > mispredict. The trap target is the
// mtvec base with its mode bits cleared.
module pipe_ctrl_redirect_sel
  import pipe_ctrl_pkg::*;
(
  input  logic        excp_valid,
  input  logic        mret,
  input  logic        mispredict,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  input  logic [31:0] real_tar_addr,
  output ev_kind_t    kind,
  output logic [31:0] target
);
  always_comb begin
    kind   = EV_NONE;
    target = 32'h0;
    if (excp_valid) begin
      kind   = EV_EXCP;
      target = mtvec & 32'hFFFF_FFFC;
    end else if (mret) begin
      kind   = EV_MRET;
      target = mepc;
    end else if (mispredict) begin
      kind   = EV_MISP;
      target = real_tar_addr;
    end
  end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall / flush / redirect controller.
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - pipe_ctrl_if.slave: stage stall requests, redirect events
//          (mispredict, mret, exception), stall vector, flush strobe,
//          redirect PC, trap CSR write port, debug FSM state.
// RUN  : stall follows the deepest requesting stage. A redirect event
//        flushes next cycle, or waits in PEND while a fetch is in flight.
// PEND : everything held; a strictly higher-priority event replaces the
//        latched one. Leaves for FLUSH once the fetch completes.
// FLUSH: one-cycle flush strobe with the redirect PC; events ignored.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  pipe_ctrl_if.slave   bus
);
  state_t      state_q, state_d;
  ev_kind_t    lat_kind_q, lat_kind_d;
  logic [31:0] lat_tar_q, lat_tar_d;
  logic [31:0] lat_pc_q, lat_pc_d;
  logic [4:0]  lat_code_q, lat_code_d;

  ev_kind_t    cur_kind;
  logic [31:0] cur_tar;

  logic        go_flush;
  ev_kind_t    fl_kind;
  logic [31:0] fl_tar, fl_pc;
  logic [4:0]  fl_code;
  logic [5:0]  stall_c;

  logic        flush_q, mepc_we_q;
  logic [31:0] new_pc_q, mepc_q;
  logic [4:0]  mcause_q;

  pipe_ctrl_redirect_sel u_redirect_sel (
    .excp_valid    (bus.excp_valid_i),
    .mret          (bus.mret_i),
    .mispredict    (bus.mispredict_i),
    .mtvec         (bus.mtvec_i),
    .mepc          (bus.mepc_i),
    .real_tar_addr (bus.real_tar_addr_i),
    .kind          (cur_kind),
    .target        (cur_tar)
  );

  always_comb begin
    state_d    = state_q;
    lat_kind_d = lat_kind_q;
    lat_tar_d  = lat_tar_q;
    lat_pc_d   = lat_pc_q;
    lat_code_d = lat_code_q;
    go_flush   = 1'b0;
    fl_kind    = cur_kind;
    fl_tar     = cur_tar;
    fl_pc      = bus.excp_pc_i;
    fl_code    = bus.excp_code_i;
    stall_c    = STALL_NONE;
    case (state_q)
      ST_RUN: begin
        if (cur_kind != EV_NONE) begin
          // Redirect beats stage stalls: the requesting stages are flushed.
          if (bus.stallreq_if) begin
            state_d    = ST_PEND;
            lat_kind_d = cur_kind;
            lat_tar_d  = cur_tar;
            lat_pc_d   = bus.excp_pc_i;
            lat_code_d = bus.excp_code_i;
            stall_c    = STALL_ALL;
          end else begin
            state_d  = ST_FLUSH;
            go_flush = 1'b1;
          end
        end else begin
          stall_c = run_stall(bus.stallreq_if, bus.stallreq_id,
                              bus.stallreq_ex, bus.stallreq_mem);
        end
      end
      ST_PEND: begin
        stall_c = STALL_ALL;
        // Merge this cycle's event with the latched one; equal or lower
        // priority leaves the latch alone.
        if (cur_kind > lat_kind_q) begin
          lat_kind_d = cur_kind;
          lat_tar_d  = cur_tar;
          lat_pc_d   = bus.excp_pc_i;
          lat_code_d = bus.excp_code_i;
        end
        fl_kind = lat_kind_d;
        fl_tar  = lat_tar_d;
        fl_pc   = lat_pc_d;
        fl_code = lat_code_d;
        if (!bus.stallreq_if) begin
          state_d    = ST_FLUSH;
          go_flush   = 1'b1;
          lat_kind_d = EV_NONE;
        end
      end
      ST_FLUSH: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      lat_kind_q <= EV_NONE;
      lat_tar_q  <= 32'h0;
      lat_pc_q   <= 32'h0;
      lat_code_q <= 5'h0;
      flush_q    <= 1'b0;
      new_pc_q   <= RESET_PC;
      mepc_we_q  <= 1'b0;
      mepc_q     <= 32'h0;
      mcause_q   <= 5'h0;
    end else begin
      state_q    <= state_d;
      lat_kind_q <= lat_kind_d;
      lat_tar_q  <= lat_tar_d;
      lat_pc_q   <= lat_pc_d;
      lat_code_q <= lat_code_d;
      flush_q    <= go_flush;
      mepc_we_q  <= go_flush && (fl_kind == EV_EXCP);
      if (go_flush) begin
        new_pc_q <= fl_tar;
      end
      if (go_flush && (fl_kind == EV_EXCP)) begin
        mepc_q   <= fl_pc;
        mcause_q <= fl_code;
      end
    end
  end

  // Stall is forced clear while reset is held, whatever the requests say.
  assign bus.stall     = rst ? stall_c : STALL_NONE;
  assign bus.flush     = flush_q;
  assign bus.new_pc    = new_pc_q;
  assign bus.mepc_we_o = mepc_we_q;
  assign bus.mepc_o    = mepc_q;
  assign bus.mcause_o  = mcause_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl. Each cycle the stimulus side drives the
// inputs just after the rising edge and pushes the outputs it expects to
// see in that cycle; the monitor pops and compares on the falling edge.
// Expected vector layout: {stall[5:0], flush, new_pc[31:0], mepc_we,
// mepc[31:0], mcause[4:0]}.
module tb_pipe_ctrl;
  localparam int W = 77;

  logic clk;
  logic rst;
  pipe_ctrl_if bus ();

  pipe_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           total = 0;
  int           bad   = 0;

  function automatic logic [W-1:0] pack_exp(input logic [5:0] st, input logic fl,
                                            input logic [31:0] pc, input logic we,
                                            input logic [31:0] mepc, input logic [4:0] mc);
    return {st, fl, pc, we, mepc, mc};
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e, a;
      string        n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = pack_exp(bus.stall, bus.flush, bus.new_pc, bus.mepc_we_o, bus.mepc_o, bus.mcause_o);
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL %s: got stall=%b flush=%b new_pc=%h we=%b mepc=%h mcause=%0d, want stall=%b flush=%b new_pc=%h we=%b mepc=%h mcause=%0d",
                 n, a[76:71], a[70], a[69:38], a[37], a[36:5], a[4:0],
                 e[76:71], e[70], e[69:38], e[37], e[36:5], e[4:0]);
      end
    end
  end

  // driver tasks
  task automatic clear_inputs();
    bus.stallreq_if     = 1'b0;
    bus.stallreq_id     = 1'b0;
    bus.stallreq_ex     = 1'b0;
    bus.stallreq_mem    = 1'b0;
    bus.mispredict_i    = 1'b0;
    bus.real_tar_addr_i = 32'h0;
    bus.excp_valid_i    = 1'b0;
    bus.excp_code_i     = 5'h0;
    bus.excp_pc_i       = 32'h0;
    bus.mtvec_i         = 32'h0;
    bus.mret_i          = 1'b0;
    bus.mepc_i          = 32'h0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic expect_cyc(input string n, input logic [5:0] st, input logic fl,
                            input logic [31:0] pc, input logic we,
                            input logic [31:0] mepc, input logic [4:0] mc);
    exp_q.push_back(pack_exp(st, fl, pc, we, mepc, mc));
    name_q.push_back(n);
  endtask

  task automatic misp(input logic [31:0] t);
    bus.mispredict_i    = 1'b1;
    bus.real_tar_addr_i = t;
  endtask

  task automatic excp(input logic [4:0] c, input logic [31:0] pc, input logic [31:0] tv);
    bus.excp_valid_i = 1'b1;
    bus.excp_code_i  = c;
    bus.excp_pc_i    = pc;
    bus.mtvec_i      = tv;
  endtask

  task automatic mret(input logic [31:0] m);
    bus.mret_i = 1'b1;
    bus.mepc_i = m;
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    bus.stallreq_mem = 1'b1;

    // reset: stall forced clear even with a request present
    next_cycle(); bus.stallreq_mem = 1'b1;
    expect_cyc("reset", 6'b000000, 0, 32'h3000_0000, 0, 32'h0, 5'd0);

    next_cycle(); rst = 1'b1; bus.stallreq_ex = 1; bus.stallreq_id = 1;
    expect_cyc("ex_id_stall", 6'b001111, 0, 32'h3000_0000, 0, 32'h0, 5'd0);
    next_cycle(); bus.stallreq_mem = 1; bus.stallreq_ex = 1;
    expect_cyc("mem_stall", 6'b011111, 0, 32'h3000_0000, 0, 32'h0, 5'd0);
    next_cycle(); bus.stallreq_id = 1;
    expect_cyc("id_stall", 6'b000111, 0, 32'h3000_0000, 0, 32'h0, 5'd0);
    next_cycle(); bus.stallreq_if = 1;
    expect_cyc("if_stall", 6'b000011, 0, 32'h3000_0000, 0, 32'h0, 5'd0);
    next_cycle();
    expect_cyc("no_stall", 6'b000000, 0, 32'h3000_0000, 0, 32'h0, 5'd0);

    // simple mispredict
    next_cycle(); misp(32'h3000_0100);
    expect_cyc("misp_issue", 6'b000000, 0, 32'h3000_0000, 0, 32'h0, 5'd0);
    next_cycle();
    expect_cyc("misp_flush", 6'b000000, 1, 32'h3000_0100, 0, 32'h0, 5'd0);
    next_cycle();
    expect_cyc("misp_after", 6'b000000, 0, 32'h3000_0100, 0, 32'h0, 5'd0);

    // mispredict pending behind a fetch, upgraded by an exception
    next_cycle(); misp(32'h3000_0040); bus.stallreq_if = 1;
    expect_cyc("pend_enter", 6'b111111, 0, 32'h3000_0100, 0, 32'h0, 5'd0);
    next_cycle(); bus.stallreq_if = 1; excp(5'd2, 32'h3000_0020, 32'h3000_1001);
    expect_cyc("pend_excp", 6'b111111, 0, 32'h3000_0100, 0, 32'h0, 5'd0);
    next_cycle(); bus.stallreq_if = 1;
    expect_cyc("pend_hold", 6'b111111, 0, 32'h3000_0100, 0, 32'h0, 5'd0);
    next_cycle();
    expect_cyc("pend_leave", 6'b111111, 0, 32'h3000_0100, 0, 32'h0, 5'd0);
    next_cycle();
    expect_cyc("excp_flush", 6'b000000, 1, 32'h3000_1000, 1, 32'h3000_0020, 5'd2);
    next_cycle();
    expect_cyc("excp_after", 6'b000000, 0, 32'h3000_1000, 0, 32'h3000_0020, 5'd2);

    // pending exception; lower-priority events must not replace it
    next_cycle(); bus.stallreq_if = 1; excp(5'd7, 32'h3000_0080, 32'h3000_2000);
    expect_cyc("pend2_enter", 6'b111111, 0, 32'h3000_1000, 0, 32'h3000_0020, 5'd2);
    next_cycle(); bus.stallreq_if = 1; misp(32'h3000_0990);
    expect_cyc("pend2_misp", 6'b111111, 0, 32'h3000_1000, 0, 32'h3000_0020, 5'd2);
    next_cycle(); mret(32'h3000_0300);
    expect_cyc("pend2_mret", 6'b111111, 0, 32'h3000_1000, 0, 32'h3000_0020, 5'd2);
    next_cycle();
    expect_cyc("pend2_flush", 6'b000000, 1, 32'h3000_2000, 1, 32'h3000_0080, 5'd7);
    next_cycle();
    expect_cyc("pend2_after", 6'b000000, 0, 32'h3000_2000, 0, 32'h3000_0080, 5'd7);

    // mret beats mispredict; events during FLUSH ignored
    next_cycle(); mret(32'h3000_0200); misp(32'h3000_0500);
    expect_cyc("mret_issue", 6'b000000, 0, 32'h3000_2000, 0, 32'h3000_0080, 5'd7);
    next_cycle(); excp(5'd3, 32'h3000_0aa0, 32'h3000_3000); misp(32'h3000_0bb0);
    bus.stallreq_mem = 1;
    expect_cyc("mret_flush", 6'b000000, 1, 32'h3000_0200, 0, 32'h3000_0080, 5'd7);
    next_cycle();
    expect_cyc("flush_ign1", 6'b000000, 0, 32'h3000_0200, 0, 32'h3000_0080, 5'd7);
    next_cycle();
    expect_cyc("flush_ign2", 6'b000000, 0, 32'h3000_0200, 0, 32'h3000_0080, 5'd7);

    // redirect overrides a concurrent stage stall
    next_cycle(); misp(32'h3000_0444); bus.stallreq_mem = 1;
    expect_cyc("ev_vs_stall", 6'b000000, 0, 32'h3000_0200, 0, 32'h3000_0080, 5'd7);
    next_cycle();
    expect_cyc("ev_vs_flush", 6'b000000, 1, 32'h3000_0444, 0, 32'h3000_0080, 5'd7);
    next_cycle();
    expect_cyc("ev_vs_after", 6'b000000, 0, 32'h3000_0444, 0, 32'h3000_0080, 5'd7);

    // reset during PEND discards the redirect
    next_cycle(); misp(32'h3000_0888); bus.stallreq_if = 1;
    expect_cyc("rpend_enter", 6'b111111, 0, 32'h3000_0444, 0, 32'h3000_0080, 5'd7);
    next_cycle(); bus.stallreq_if = 1;
    expect_cyc("rpend_hold", 6'b111111, 0, 32'h3000_0444, 0, 32'h3000_0080, 5'd7);
    next_cycle(); rst = 1'b0; bus.stallreq_if = 1;
    expect_cyc("rpend_reset", 6'b000000, 0, 32'h3000_0000, 0, 32'h0, 5'd0);
    next_cycle(); rst = 1'b1;
    expect_cyc("rpend_rel1", 6'b000000, 0, 32'h3000_0000, 0, 32'h0, 5'd0);
    next_cycle();
    expect_cyc("rpend_rel2", 6'b000000, 0, 32'h3000_0000, 0, 32'h0, 5'd0);
    next_cycle();
    expect_cyc("rpend_rel3", 6'b000000, 0, 32'h3000_0000, 0, 32'h0, 5'd0);

    // drain, bounded
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset.
REQ-003 stallreq_if / stallreq_id / stallreq_ex / stallreq_mem  input  1 each  stall requests from fetch bus (transfer in flight), decode, execute (multi-cycle op) and memory stages.
REQ-004 mispredict_i  input  1  EX resolved branch disagrees with prediction; real_tar_addr_i  input  32  correct target.
REQ-005 excp_valid_i  input  1  MEM-stage exception; excp_code_i  input  5  cause; excp_pc_i  input  32  faulting PC; mtvec_i  input  32  trap vector base.
REQ-006 mret_i  input  1  MEM-stage mret; mepc_i  input  32  return address.
REQ-007 stall  output  6  [0]=PC, [1]=IF, [2]=ID, [3]=EX, [4]=MEM, [5]=WB; 1 = hold.
REQ-008 flush  output  1  one-cycle pipeline flush / PC redirect strobe.
REQ-009 new_pc  output  32  redirect target, valid while flush=1.
REQ-010 mepc_we_o  output  1; mepc_o  output  32; mcause_o  output  5  trap CSR write port.

Function
REQ-011 FSM states RUN, PEND, FLUSH; flush, new_pc and CSR port outputs are registered; stall is combinational from state and requests.
REQ-012 RUN stall encoding, highest request wins: mem -> 6'b011111, ex -> 6'b001111, id -> 6'b000111, if -> 6'b000011, none -> 6'b000000.
REQ-013 Redirect event priority: excp_valid_i > mret_i > mispredict_i; target = {mtvec_i[31:2],2'b00}, mepc_i, real_tar_addr_i respectively.
REQ-014 RUN, event, stallreq_if=0: next cycle state FLUSH, flush=1, new_pc=target, for exactly one cycle.
REQ-015 RUN, event, stallreq_if=1: next state PEND; target and event kind latched; stall=6'b111111 every PEND cycle.
REQ-016 PEND: higher-priority event arriving overwrites latched target/kind; lower or equal priority ignored.
REQ-017 PEND -> FLUSH on first cycle stallreq_if=0; flush=1 with latched target in the FLUSH cycle.
REQ-018 FLUSH: stall=6'b000000, all event inputs ignored; always returns to RUN next cycle.
REQ-019 Exception: mepc_we_o=1, mepc_o=excp_pc_i, mcause_o=excp_code_i in the same cycle as its flush; mepc_we_o=0 otherwise.
REQ-020 Mispredict and mret never assert mepc_we_o.
REQ-021 Event and stall request together in RUN: redirect takes precedence (stall requests from flushed stages are discarded).

Reset
REQ-022 rst=0 asynchronously forces: state RUN, flush=0, new_pc=32'h3000_0000, mepc_we_o=0, mepc_o=0, mcause_o=0, latched target cleared.
REQ-023 stall=6'b000000 while in reset; any PEND redirect is discarded by reset mid-operation.

Structure
REQ-024 Shared package/define file holds stall encodings, FSM state codes, reset PC 32'h3000_0000 and event-kind codes.
REQ-025 One sub-module: redirect_sel (combinational priority selector producing event kind and target); FSM and registers stay in pipe_ctrl.

Verification
REQ-026 stallreq_ex=1, stallreq_id=1, no events -> stall=6'b001111, flush=0.
REQ-027 mispredict_i=1, real_tar_addr_i=32'h3000_0100, stallreq_if=0 -> next cycle flush=1, new_pc=32'h3000_0100, one cycle only, mepc_we_o=0.
REQ-028 mispredict_i=1 (target 32'h3000_0040) with stallreq_if=1 for 3 cycles, excp_valid_i=1 (code 5'd2, pc 32'h3000_0020, mtvec 32'h3000_1001) in the 2nd -> stall=6'b111111 throughout, then flush=1, new_pc=32'h3000_1000, mepc_we_o=1, mepc_o=32'h3000_0020, mcause_o=2.
REQ-029 mret_i=1, mepc_i=32'h3000_0200 in same cycle as mispredict_i=1 -> new_pc=32'h3000_0200.
REQ-030 Events asserted during FLUSH cycle -> ignored; no second flush.
REQ-031 rst low during PEND -> immediate RUN, flush=0, new_pc=32'h3000_0000; no flush after release.
